// File: rtl/receive_fsm.sv
// Operand-assembly stage: groups every four accepted read words into one
// operation (A, B, and a double-width C built from the 3rd and 4th words).
module receive_fsm #(
    parameter int DATA_W   = 20,
    parameter int W_DATA_W = 2 * DATA_W
) (
    input  logic                clk,
    input  logic                arst_ni,
    input  logic                rd_data_valid_i,
    input  logic [DATA_W-1:0]   rd_data_i,
    output logic [DATA_W-1:0]   operand_a_o,
    output logic [DATA_W-1:0]   operand_b_o,
    output logic [W_DATA_W-1:0] operand_c_o,
    output logic                operation_valid_o
);

    typedef enum logic [1:0] {
        GET_A    = 2'd0,
        GET_B    = 2'd1,
        GET_C_LO = 2'd2,
        GET_C_HI = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] stage_a;
    logic [DATA_W-1:0] stage_b;
    logic [DATA_W-1:0] stage_c_lo;

    // Staging registers absorb the first three words so the visible operand
    // set only ever changes, all at once, on the edge that takes the 4th word.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state             <= GET_A;
            stage_a           <= '0;
            stage_b           <= '0;
            stage_c_lo        <= '0;
            operand_a_o       <= '0;
            operand_b_o       <= '0;
            operand_c_o       <= '0;
            operation_valid_o <= 1'b0;
        end else begin
            operation_valid_o <= 1'b0;
            if (rd_data_valid_i) begin
                case (state)
                    GET_A: begin
                        stage_a <= rd_data_i;
                        state   <= GET_B;
                    end
                    GET_B: begin
                        stage_b <= rd_data_i;
                        state   <= GET_C_LO;
                    end
                    GET_C_LO: begin
                        stage_c_lo <= rd_data_i;
                        state      <= GET_C_HI;
                    end
                    GET_C_HI: begin
                        operand_a_o       <= stage_a;
                        operand_b_o       <= stage_b;
                        operand_c_o       <= {rd_data_i, stage_c_lo};
                        operation_valid_o <= 1'b1;
                        state             <= GET_A;
                    end
                    default: state <= GET_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receive_fsm.sv
// Scoreboard bench for receive_fsm: the driver records expected operand sets,
// a monitor one time unit after each rising edge checks pulse and operands.
module tb_receive_fsm;

    localparam int DATA_W   = 20;
    localparam int W_DATA_W = 40;

    typedef struct {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [W_DATA_W-1:0] c;
    } exp_t;

    logic                clk = 1'b0;
    logic                arst_ni = 1'b1;
    logic                rd_data_valid_i = 1'b0;
    logic [DATA_W-1:0]   rd_data_i = '0;
    logic [DATA_W-1:0]   operand_a_o;
    logic [DATA_W-1:0]   operand_b_o;
    logic [W_DATA_W-1:0] operand_c_o;
    logic                operation_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t              sb_q[$];
    exp_t              held;
    logic [DATA_W-1:0] m_a, m_b, m_clo;
    int                word_idx = 0;
    bit                fourth   = 1'b0;
    bit                mon_en   = 1'b0;

    receive_fsm #(.DATA_W(DATA_W), .W_DATA_W(W_DATA_W)) dut (
        .clk               (clk),
        .arst_ni           (arst_ni),
        .rd_data_valid_i   (rd_data_valid_i),
        .rd_data_i         (rd_data_i),
        .operand_a_o       (operand_a_o),
        .operand_b_o       (operand_b_o),
        .operand_c_o       (operand_c_o),
        .operation_valid_o (operation_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and record what the
    // following rising edge should produce.
    task automatic drive(input bit v, input logic [DATA_W-1:0] d);
        exp_t e;
        @(negedge clk);
        rd_data_valid_i = v;
        rd_data_i       = d;
        fourth          = 1'b0;
        if (v) begin
            case (word_idx)
                0: m_a   = d;
                1: m_b   = d;
                2: m_clo = d;
                default: begin
                    e.a = m_a;
                    e.b = m_b;
                    e.c = {d, m_clo};
                    sb_q.push_back(e);
                    fourth = 1'b1;
                end
            endcase
            word_idx = (word_idx + 1) % 4;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 20'h0);
    endtask

    task automatic do_reset(input int len);
        @(negedge clk);
        arst_ni         = 1'b0;
        rd_data_valid_i = 1'b0;
        fourth          = 1'b0;
        word_idx        = 0;
        sb_q.delete();
        held.a = '0;
        held.b = '0;
        held.c = '0;
        #1;
        check("rst_valid", {63'b0, operation_valid_o}, 64'd0);
        check("rst_a", {44'b0, operand_a_o}, 64'd0);
        check("rst_b", {44'b0, operand_b_o}, 64'd0);
        check("rst_c", {24'b0, operand_c_o}, 64'd0);
        #(len - 1);
        @(negedge clk);
        arst_ni = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && arst_ni) begin
            check("pulse", {63'b0, operation_valid_o}, {63'b0, fourth});
            if (fourth && sb_q.size() > 0) held = sb_q.pop_front();
            check("op_a", {44'b0, operand_a_o}, {44'b0, held.a});
            check("op_b", {44'b0, operand_b_o}, {44'b0, held.b});
            check("op_c", {24'b0, operand_c_o}, {24'b0, held.c});
        end
    end

    logic [DATA_W-1:0] seq12 [12] = '{20'hABCDE, 20'hDEADF, 20'hCAFEA, 20'hFADED,
                                      20'hCBBDE, 20'hFBAAE, 20'hDEADF, 20'hCAFEA,
                                      20'hFADED, 20'hDEADF, 20'hCAFEA, 20'hFADED};

    initial begin
        held.a = '0;
        held.b = '0;
        held.c = '0;
        #1;
        do_reset(20);
        mon_en = 1'b1;
        idle(3);

        // Single operation, continuous valid
        for (int i = 0; i < 4; i++) drive(1'b1, seq12[i]);
        idle(2);
        check("single_c", {24'b0, operand_c_o}, {24'b0, 40'hFADED_CAFEA});
        check("single_a", {44'b0, operand_a_o}, {44'b0, 20'hABCDE});

        // Back-to-back operations
        for (int i = 0; i < 12; i++) drive(1'b1, seq12[i]);
        idle(2);
        check("b2b_a", {44'b0, operand_a_o}, {44'b0, 20'hFADED});
        check("b2b_b", {44'b0, operand_b_o}, {44'b0, 20'hDEADF});

        // Stalls of 3 cycles between words
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq12[i]);
            if (i < 3) idle(3);
        end
        idle(2);
        check("stall_c", {24'b0, operand_c_o}, {24'b0, 40'hFADED_CAFEA});

        // Reset in the middle of an operation
        drive(1'b1, 20'h11111);
        drive(1'b1, 20'h22222);
        do_reset(20);
        idle(2);
        drive(1'b1, 20'h12345);
        drive(1'b1, 20'h23456);
        drive(1'b1, 20'h34567);
        drive(1'b1, 20'h45678);
        idle(2);
        check("mid_rst_a", {44'b0, operand_a_o}, {44'b0, 20'h12345});
        check("mid_rst_b", {44'b0, operand_b_o}, {44'b0, 20'h23456});
        check("mid_rst_c", {24'b0, operand_c_o}, {24'b0, 40'h45678_34567});

        // Valid held with constant data: one operation per 4 cycles
        for (int i = 0; i < 12; i++) drive(1'b1, 20'h5A5A5);
        idle(2);
        check("const_c", {24'b0, operand_c_o}, {24'b0, 40'h5A5A5_5A5A5});

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
